// File: rtl/alu_result_stage.sv
// Two-entry result buffer between the ALU and its consumer, with a result counter.
// Optional sticky flag accumulator enabled by defining ALU_RESULT_STAGE_STICKY_EN.
module alu_result_stage #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       ALU_OUT_TMP,
  input  logic [3:0]       FLAG_TMP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [7:0]       ALU_OUT,
  output logic [3:0]       FLAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [3:0]       FLAG_STICKY,
  input  logic             CLR_STICKY,
  output logic [CNT_W-1:0] RESULT_CNT
);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_t;

  occ_t       occ;
  occ_t       occ_nxt;
  logic [7:0] tail_alu;
  logic [3:0] tail_flag;
  logic       push;
  logic       pop;

  assign push = IN_VALID & IN_READY;
  assign pop  = OUT_VALID & OUT_READY;

  always_comb begin
    occ_nxt = occ;
    case (occ)
      OCC_EMPTY: if (push) occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (push && !pop)      occ_nxt = OCC_FULL;
        else if (!push && pop) occ_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (pop) occ_nxt = OCC_ONE;
      default:   occ_nxt = OCC_EMPTY;
    endcase
  end

  // ALU_OUT/FLAG are the head slot itself; the tail slot is only used when full.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      occ        <= OCC_EMPTY;
      IN_READY   <= 1'b1;
      OUT_VALID  <= 1'b0;
      ALU_OUT    <= '0;
      FLAG       <= '0;
      tail_alu   <= '0;
      tail_flag  <= '0;
      RESULT_CNT <= '0;
    end else begin
      occ       <= occ_nxt;
      IN_READY  <= (occ_nxt != OCC_FULL);
      OUT_VALID <= (occ_nxt != OCC_EMPTY);
      if (push) RESULT_CNT <= RESULT_CNT + 1'b1;
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            ALU_OUT <= ALU_OUT_TMP;
            FLAG    <= FLAG_TMP;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            ALU_OUT <= ALU_OUT_TMP;
            FLAG    <= FLAG_TMP;
          end else if (push) begin
            tail_alu  <= ALU_OUT_TMP;
            tail_flag <= FLAG_TMP;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            ALU_OUT <= tail_alu;
            FLAG    <= tail_flag;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_RESULT_STAGE_STICKY_EN
  logic [3:0] sticky_q;

  // A clear coinciding with a push keeps only that push's flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sticky_q <= '0;
    end else if (push) begin
      sticky_q <= CLR_STICKY ? FLAG_TMP : (sticky_q | FLAG_TMP);
    end else if (CLR_STICKY) begin
      sticky_q <= '0;
    end
  end

  assign FLAG_STICKY = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = CLR_STICKY;
  assign FLAG_STICKY       = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed, table-driven bench for alu_result_stage (counter width 2 to reach wrap quickly).
module tb_alu_result_stage;

  localparam int unsigned CW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [7:0]    ALU_OUT_TMP;
  logic [3:0]    FLAG_TMP;
  logic          IN_VALID;
  logic          IN_READY;
  logic [7:0]    ALU_OUT;
  logic [3:0]    FLAG;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [3:0]    FLAG_STICKY;
  logic          CLR_STICKY;
  logic [CW-1:0] RESULT_CNT;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_stage #(.CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .ALU_OUT_TMP(ALU_OUT_TMP), .FLAG_TMP(FLAG_TMP),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ALU_OUT(ALU_OUT), .FLAG(FLAG),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .FLAG_STICKY(FLAG_STICKY),
    .CLR_STICKY(CLR_STICKY), .RESULT_CNT(RESULT_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       iv;
    logic [7:0] alu;
    logic [3:0] flg;
    logic       ord;
    logic       clr;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_alu;
    logic [3:0] e_flg;
    int         e_cnt;
    logic [3:0] e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] st(input logic [3:0] x);
`ifdef ALU_RESULT_STAGE_STICKY_EN
    return x;
`else
    return 4'h0;
`endif
  endfunction

  task automatic add(input logic iv, input logic [7:0] alu, input logic [3:0] flg,
                     input logic ord, input logic clr, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_alu, input logic [3:0] e_flg, input int e_cnt,
                     input logic [3:0] e_st);
    vec_t v;
    v.iv = iv; v.alu = alu; v.flg = flg; v.ord = ord; v.clr = clr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_alu = e_alu; v.e_flg = e_flg;
    v.e_cnt = e_cnt; v.e_st = st(e_st);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] alu, input logic [3:0] flg,
                       input logic ord, input logic clr);
    IN_VALID = iv; ALU_OUT_TMP = alu; FLAG_TMP = flg; OUT_READY = ord; CLR_STICKY = clr;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
  endtask

  initial begin
    //  iv   alu    flg   ord  clr   ir   ov   e_alu  e_flg cnt e_st
    add(1'b1, 8'h02, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 4'h0, 1, 4'h0); // first push
    add(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 1, 4'h0); // drained
    add(1'b1, 8'h2C, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2C, 4'h2, 2, 4'h2);
    add(1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2C, 4'h2, 3, 4'h3); // full
    add(1'b1, 8'h55, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2C, 4'h2, 3, 4'h3); // 55 refused
    add(1'b1, 8'h55, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h1, 3, 4'h3); // pop, 55 ignored
    add(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 3, 4'h3); // empty
    add(1'b1, 8'h46, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h46, 4'h0, 0, 4'h3); // cnt wraps
    add(1'b1, 8'h07, 4'h8, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 4'h8, 1, 4'hB); // push+pop
    add(1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h07, 4'h8, 1, 4'h0); // clear
    add(1'b1, 8'h11, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 4'h8, 2, 4'h2);
    add(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 4'h8, 2, 4'h2); // hold
    add(1'b1, 8'h33, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 4'h8, 2, 4'h2); // refused
    add(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 4'h2, 2, 4'h2);
    add(1'b1, 8'h22, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'h2, 3, 4'hA);
    add(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 4'h8, 3, 4'hA);
    add(1'b1, 8'h44, 4'h1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 4'h1, 0, 4'h1); // clear + push
    add(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 0, 4'h1);
    add(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h0, 0, 4'h1); // pop on empty

    do_reset();
    chk("rst_ov", int'(OUT_VALID), 0);
    chk("rst_alu", int'(ALU_OUT), 8'h00);
    chk("rst_flg", int'(FLAG), 4'h0);
    chk("rst_cnt", int'(RESULT_CNT), 0);
    chk("rst_st", int'(FLAG_STICKY), 0);
    chk("rst_ir", int'(IN_READY), 1);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].alu, vecs[i].flg, vecs[i].ord, vecs[i].clr);
      step();
      chk($sformatf("v%0d_ir", i), int'(IN_READY), int'(vecs[i].e_ir));
      chk($sformatf("v%0d_ov", i), int'(OUT_VALID), int'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_alu", i), int'(ALU_OUT), int'(vecs[i].e_alu));
        chk($sformatf("v%0d_flg", i), int'(FLAG), int'(vecs[i].e_flg));
      end
      chk($sformatf("v%0d_cnt", i), int'(RESULT_CNT), vecs[i].e_cnt);
      chk($sformatf("v%0d_st", i), int'(FLAG_STICKY), int'(vecs[i].e_st));
    end

    // Counter wrap over five pushes, then reset with two entries buffered.
    do_reset();
    for (int unsigned k = 0; k < 5; k++) begin
      drive(1'b1, 8'(8'h80 + k), 4'h0, 1'b1, 1'b0);
      step();
      chk($sformatf("wrap%0d_cnt", k), int'(RESULT_CNT), int'((k + 1) % 4));
      chk($sformatf("wrap%0d_alu", k), int'(ALU_OUT), int'(8'h80 + k));
    end
    drive(1'b1, 8'h99, 4'h0, 1'b0, 1'b0);
    step();
    chk("two_ir", int'(IN_READY), 0);
    chk("two_cnt", int'(RESULT_CNT), 2);
    RESET = 1'b1;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    step();
    chk("mid_rst_ov", int'(OUT_VALID), 0);
    chk("mid_rst_ir", int'(IN_READY), 1);
    chk("mid_rst_cnt", int'(RESULT_CNT), 0);

    // A push offered while reset is asserted is lost.
    RESET = 1'b0;
    drive(1'b1, 8'h5A, 4'hF, 1'b0, 1'b0);
    step();
    chk("pre_cnt", int'(RESULT_CNT), 1);
    RESET = 1'b1;
    drive(1'b1, 8'hA5, 4'hF, 1'b0, 1'b0);
    step();
    RESET = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
    step();
    chk("rst_push_ov", int'(OUT_VALID), 0);
    chk("rst_push_cnt", int'(RESULT_CNT), 0);
    chk("rst_push_ir", int'(IN_READY), 1);
    chk("rst_push_st", int'(FLAG_STICKY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
